rsa_key_setup: RTL and testbench
================================

Name: rsa_key_setup

Overview:
- Key-preparation stage around the extended binary GCD.
- Upstream side: from primes p, q it computes n = p*q and phi = (p-1)*(q-1) with sequential shift-add multipliers, then launches the GCD unit on (e, phi).
- Downstream side: consumes the GCD result and Bezout coefficient, checks that gcd = 1, and normalises the coefficient into the private exponent d in [0, phi).
- Sits between key input registers and the modular-exponentiation core.

Parameters:
- WORD_WIDTH, 32, width of n, phi, e, d and the GCD datapath; must be even and >= 8.
- HALF_WIDTH, WORD_WIDTH/2, width of p and q (derived; not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  level request; rising edge (0->1 in IDLE) starts one key setup
- p  in  HALF_WIDTH  prime p, sampled at start
- q  in  HALF_WIDTH  prime q, sampled at start
- e  in  WORD_WIDTH  public exponent, sampled at start
- done  out  1  high in DONE state until enable deasserted
- error  out  1  valid with done; 1 = no valid key
- n  out  WORD_WIDTH  modulus p*q
- phi  out  WORD_WIDTH  (p-1)*(q-1)
- d  out  WORD_WIDTH  private exponent; 0 when error
- gcd_enable  out  1  to GCD unit enable
- gcd_x  out  WORD_WIDTH  to GCD x (= e)
- gcd_y  out  WORD_WIDTH  to GCD y (= phi)
- gcd_done  in  1  from GCD done
- gcd_result  in  WORD_WIDTH  from GCD gcd_result
- gcd_coeff_i  in  WORD_WIDTH signed  from GCD coeff_i (coefficient of x: coeff_i*x + coeff_j*y = gcd)

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; done, error, gcd_enable = 0; n, phi, d, gcd_x, gcd_y = 0. Reset wins over any state, including mid-MUL or mid-GCD; gcd_enable drops the same edge.
- IDLE: p, q, e latched on the edge where enable=1 and the previous enable=0, then go to MUL. enable held high from reset release also counts as a start.
- MUL: two parallel shift-add multipliers, (p, q) and (p-1, q-1), one multiplier bit per cycle; exactly HALF_WIDTH cycles; results full WORD_WIDTH, no overflow possible. Then CHECK.
- CHECK (1 cycle): error if p < 2, q < 2, e < 2, or e >= phi, going to DONE. Otherwise drive gcd_x = e, gcd_y = phi, and go to GCD_RUN.
- GCD_RUN: gcd_enable = 1, with gcd_x/gcd_y held stable. Wait for gcd_done = 1, capture gcd_result and gcd_coeff_i, deassert gcd_enable the next cycle, go to GCD_CHK. No timeout.
- GCD_CHK (1 cycle): gcd_result != 1 -> error, DONE. Otherwise load a signed WORD_WIDTH+1-bit accumulator with sign-extended coeff_i, go to NORM.
- NORM: one operation per cycle: if acc < 0, acc += phi; else if acc >= phi, acc -= phi; else d = acc[WORD_WIDTH-1:0], go to DONE. Bounded by |coeff_i|/phi + 1 cycles.
- DONE: done = 1, with error, n, phi, d stable. On enable = 0, go to IDLE; done and error clear next cycle; n, phi, d keep their values.
- Error path: d = 0; n and phi still reported if MUL completed.
- enable deasserted mid-operation is ignored; the operation completes.

Test Plan:
- p=5, q=11, e=3, enable held -> after 16+ cycles done=1, error=0, n=55, phi=40, d=27; GCD saw x=3, y=40.
- p=61, q=53, e=17 -> n=3233, phi=3120, d=2753, error=0; gcd_enable high only in GCD_RUN and low the cycle after gcd_done.
- p=5, q=11, e=4 -> gcd_result=4 -> done=1, error=1, d=0, n=55, phi=40.
- p=1, q=11, e=3 -> done=1, error=1 from CHECK; gcd_enable never asserted.
- Stubbed GCD returning coeff_i=-13 with phi=40, e=3 -> d=27. Stub returning coeff_i=107 -> d=27 after 2 subtractions.
- reset=0 for one cycle mid-MUL and again mid-GCD_RUN -> all outputs 0, state IDLE. Re-assert enable with p=5, q=11, e=3 -> d=27. Enable dropped in DONE -> done=0 next cycle.

Source files
------------

// File: rtl/rsa_key_setup.sv
// rsa_key_setup
//   Key-preparation stage wrapped around an external extended binary GCD unit.
//   From primes p, q it forms n = p*q and phi = (p-1)*(q-1) with two parallel
//   shift-add multipliers, launches the GCD unit on (e, phi), checks that the
//   gcd is 1 and reduces the Bezout coefficient of e into d in [0, phi).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   enable            level request; a 0->1 edge seen in IDLE starts a setup
//   p, q, e           key inputs, sampled on the start edge
//   done, error       result strobe (held until enable drops) and no-key flag
//   n, phi, d         modulus, totient, private exponent (d = 0 on error)
//   gcd_enable/x/y    request to the GCD unit (x = e, y = phi)
//   gcd_done/result/coeff_i   response from the GCD unit
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a rising edge on enable
// S_MUL     | one multiplier bit per cycle for HALF_WIDTH cycles
// S_CHECK   | range checks on p, q, e against phi
// S_GCD_RUN | gcd_enable high until gcd_done is seen
// S_GCD_CHK | gcd must be 1
// S_NORM    | add/subtract phi until the coefficient lies in [0, phi)
// S_DONE    | done high; waits for enable to drop
module rsa_key_setup #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [WORD_WIDTH/2-1:0]      p,
  input  logic [WORD_WIDTH/2-1:0]      q,
  input  logic [WORD_WIDTH-1:0]        e,
  output logic                         done,
  output logic                         error,
  output logic [WORD_WIDTH-1:0]        n,
  output logic [WORD_WIDTH-1:0]        phi,
  output logic [WORD_WIDTH-1:0]        d,
  output logic                         gcd_enable,
  output logic [WORD_WIDTH-1:0]        gcd_x,
  output logic [WORD_WIDTH-1:0]        gcd_y,
  input  logic                         gcd_done,
  input  logic [WORD_WIDTH-1:0]        gcd_result,
  input  logic signed [WORD_WIDTH-1:0] gcd_coeff_i
);

  localparam int HALF_WIDTH = WORD_WIDTH / 2;
  localparam int CNT_W      = $clog2(HALF_WIDTH);

  localparam logic [HALF_WIDTH-1:0] H_ONE = HALF_WIDTH'(1);
  localparam logic [HALF_WIDTH-1:0] H_TWO = HALF_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] W_ONE = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] W_TWO = WORD_WIDTH'(2);
  localparam logic [CNT_W-1:0]      C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]      C_TOP = CNT_W'(HALF_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_CHECK,
    S_GCD_RUN,
    S_GCD_CHK,
    S_NORM,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    en_prev_q, en_prev_d;
  logic [HALF_WIDTH-1:0]   p_lat_q, p_lat_d;
  logic [HALF_WIDTH-1:0]   q_lat_q, q_lat_d;
  logic [WORD_WIDTH-1:0]   e_lat_q, e_lat_d;
  logic [WORD_WIDTH-1:0]   n_mcand_q, n_mcand_d;
  logic [HALF_WIDTH-1:0]   n_mplier_q, n_mplier_d;
  logic [WORD_WIDTH-1:0]   phi_mcand_q, phi_mcand_d;
  logic [HALF_WIDTH-1:0]   phi_mplier_q, phi_mplier_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   n_q, n_d;
  logic [WORD_WIDTH-1:0]   phi_q, phi_d;
  logic [WORD_WIDTH-1:0]   d_q, d_d;
  logic                    error_q, error_d;
  logic                    gcd_en_q, gcd_en_d;
  logic [WORD_WIDTH-1:0]   gcd_x_q, gcd_x_d;
  logic [WORD_WIDTH-1:0]   gcd_y_q, gcd_y_d;
  logic [WORD_WIDTH-1:0]   res_q, res_d;
  // Two's complement, one bit wider than the word so a negative coefficient
  // plus phi, or a positive one minus phi, never overflows.
  logic [WORD_WIDTH:0]     acc_q, acc_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      en_prev_q    <= 1'b0;
      p_lat_q      <= '0;
      q_lat_q      <= '0;
      e_lat_q      <= '0;
      n_mcand_q    <= '0;
      n_mplier_q   <= '0;
      phi_mcand_q  <= '0;
      phi_mplier_q <= '0;
      cnt_q        <= '0;
      n_q          <= '0;
      phi_q        <= '0;
      d_q          <= '0;
      error_q      <= 1'b0;
      gcd_en_q     <= 1'b0;
      gcd_x_q      <= '0;
      gcd_y_q      <= '0;
      res_q        <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      en_prev_q    <= en_prev_d;
      p_lat_q      <= p_lat_d;
      q_lat_q      <= q_lat_d;
      e_lat_q      <= e_lat_d;
      n_mcand_q    <= n_mcand_d;
      n_mplier_q   <= n_mplier_d;
      phi_mcand_q  <= phi_mcand_d;
      phi_mplier_q <= phi_mplier_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      phi_q        <= phi_d;
      d_q          <= d_d;
      error_q      <= error_d;
      gcd_en_q     <= gcd_en_d;
      gcd_x_q      <= gcd_x_d;
      gcd_y_q      <= gcd_y_d;
      res_q        <= res_d;
      acc_q        <= acc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    // en_prev clears in reset, so enable held high through reset release
    // looks like a fresh rising edge.
    en_prev_d    = enable;
    p_lat_d      = p_lat_q;
    q_lat_d      = q_lat_q;
    e_lat_d      = e_lat_q;
    n_mcand_d    = n_mcand_q;
    n_mplier_d   = n_mplier_q;
    phi_mcand_d  = phi_mcand_q;
    phi_mplier_d = phi_mplier_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    phi_d        = phi_q;
    d_d          = d_q;
    error_d      = error_q;
    gcd_en_d     = gcd_en_q;
    gcd_x_d      = gcd_x_q;
    gcd_y_d      = gcd_y_q;
    res_d        = res_q;
    acc_d        = acc_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !en_prev_q) begin
          p_lat_d      = p;
          q_lat_d      = q;
          e_lat_d      = e;
          n_mcand_d    = {{HALF_WIDTH{1'b0}}, p};
          n_mplier_d   = q;
          phi_mcand_d  = {{HALF_WIDTH{1'b0}}, p - H_ONE};
          phi_mplier_d = q - H_ONE;
          n_d          = '0;
          phi_d        = '0;
          cnt_d        = C_TOP;
          state_d      = S_MUL;
        end
      end

      S_MUL: begin
        if (n_mplier_q[0]) n_d = n_q + n_mcand_q;
        if (phi_mplier_q[0]) phi_d = phi_q + phi_mcand_q;
        n_mcand_d    = n_mcand_q << 1;
        n_mplier_d   = n_mplier_q >> 1;
        phi_mcand_d  = phi_mcand_q << 1;
        phi_mplier_d = phi_mplier_q >> 1;
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - C_ONE;
      end

      S_CHECK: begin
        if (p_lat_q < H_TWO || q_lat_q < H_TWO || e_lat_q < W_TWO || e_lat_q >= phi_q) begin
          error_d = 1'b1;
          d_d     = '0;
          state_d = S_DONE;
        end else begin
          gcd_x_d  = e_lat_q;
          gcd_y_d  = phi_q;
          gcd_en_d = 1'b1;
          state_d  = S_GCD_RUN;
        end
      end

      S_GCD_RUN: begin
        if (gcd_done) begin
          res_d    = gcd_result;
          acc_d    = {gcd_coeff_i[WORD_WIDTH-1], gcd_coeff_i};
          gcd_en_d = 1'b0;
          state_d  = S_GCD_CHK;
        end
      end

      S_GCD_CHK: begin
        if (res_q != W_ONE) begin
          error_d = 1'b1;
          d_d     = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (acc_q[WORD_WIDTH]) begin
          acc_d = acc_q + {1'b0, phi_q};
        end else if (acc_q[WORD_WIDTH-1:0] >= phi_q) begin
          acc_d = acc_q - {1'b0, phi_q};
        end else begin
          d_d     = acc_q[WORD_WIDTH-1:0];
          error_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (!enable) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign n          = n_q;
  assign phi        = phi_q;
  assign d          = d_q;
  assign gcd_enable = gcd_en_q;
  assign gcd_x      = gcd_x_q;
  assign gcd_y      = gcd_y_q;

endmodule

// File: tb/tb_rsa_key_setup.sv
// Testbench for rsa_key_setup with a behavioural extended-GCD stub.
module tb_rsa_key_setup;
  localparam int W = 32;
  localparam int H = W / 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [H-1:0]        p, q;
  logic [W-1:0]        e;
  logic                done, error;
  logic [W-1:0]        n, phi, d;
  logic                gcd_enable;
  logic [W-1:0]        gcd_x, gcd_y;
  logic                gcd_done;
  logic [W-1:0]        gcd_result;
  logic signed [W-1:0] gcd_coeff_i;

  always #5 clk = ~clk;

  rsa_key_setup #(.WORD_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .p           (p),
    .q           (q),
    .e           (e),
    .done        (done),
    .error       (error),
    .n           (n),
    .phi         (phi),
    .d           (d),
    .gcd_enable  (gcd_enable),
    .gcd_x       (gcd_x),
    .gcd_y       (gcd_y),
    .gcd_done    (gcd_done),
    .gcd_result  (gcd_result),
    .gcd_coeff_i (gcd_coeff_i)
  );

  typedef struct packed {
    logic         err;
    logic [W-1:0] n;
    logic [W-1:0] phi;
    logic [W-1:0] d;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // GCD stub controls and observations
  int                  stub_lat    = 3;
  bit                  stub_force  = 1'b0;
  logic [W-1:0]        force_res   = '0;
  logic signed [W-1:0] force_coeff = '0;
  int                  stub_cnt    = 0;
  int                  gen_viol    = 0;
  int                  gen_runs    = 0;
  logic [W-1:0]        seen_x      = '0;
  logic [W-1:0]        seen_y      = '0;

  function automatic void egcd(input longint a, input longint b, output longint g, output longint s);
    longint old_r = a, r = b, old_s = 1, s1 = 0, qt, t;
    while (r != 0) begin
      qt = old_r / r;
      t = old_r - qt * r; old_r = r; r = t;
      t = old_s - qt * s1; old_s = s1; s1 = t;
    end
    g = old_r;
    s = old_s;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("err=%0d n=%0d phi=%0d d=%0d", r.err, r.n, r.phi, r.d);
  endfunction

  // Expected key for given inputs, independent of the DUT datapath.
  function automatic res_t model(input longint pp, input longint qq, input longint ee);
    res_t   r;
    longint nn, ph, g, s;
    nn = pp * qq;
    ph = (pp - 1) * (qq - 1);
    r.n = W'(nn);
    r.phi = W'(ph);
    r.err = 1'b1;
    r.d = '0;
    if (pp >= 2 && qq >= 2 && ee >= 2 && ee < ph) begin
      egcd(ee, ph, g, s);
      if (g == 1) begin
        r.err = 1'b0;
        r.d = W'(((s % ph) + ph) % ph);
      end
    end
    return r;
  endfunction

  // Stub: answers gcd_enable after stub_lat cycles; flags gcd_enable still
  // high a cycle after gcd_done, or x/y moving while the request is open.
  always @(negedge clk) begin
    longint g, s;
    if (!gcd_enable) begin
      gcd_done = 1'b0;
      stub_cnt = 0;
    end else begin
      if (gcd_done) gen_viol++;
      if (stub_cnt == 0) begin
        seen_x = gcd_x;
        seen_y = gcd_y;
        gen_runs++;
      end else if (gcd_x !== seen_x || gcd_y !== seen_y) begin
        gen_viol++;
      end
      if (!gcd_done && stub_cnt >= stub_lat) begin
        if (stub_force) begin
          gcd_result  = force_res;
          gcd_coeff_i = force_coeff;
        end else begin
          egcd(longint'(gcd_x), longint'(gcd_y), g, s);
          gcd_result  = W'(g);
          gcd_coeff_i = W'(s);
        end
        gcd_done = 1'b1;
      end
      stub_cnt++;
    end
  end

  // Starts one setup at a negedge and waits (bounded) for done.
  // first_gen: negedge index where gcd_enable was first high (-1 if never);
  // post_gen: negedges from gcd_enable falling until done.
  task automatic run_key(input logic [H-1:0] pp, input logic [H-1:0] qq, input logic [W-1:0] ee,
                         input bit drop_en, output bit got, output res_t obs,
                         output int first_gen, output int post_gen);
    bit prev = 1'b0;
    p = pp; q = qq; e = ee;
    enable = 1'b1;
    got = 1'b0; first_gen = -1; post_gen = -1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (drop_en && i == 2) enable = 1'b0;
      if (gcd_enable && first_gen < 0) first_gen = i;
      if (prev && !gcd_enable) post_gen = 0;
      else if (post_gen >= 0) post_gen++;
      prev = gcd_enable;
      if (done) got = 1'b1;
    end
    obs = {error, n, phi, d};
  endtask

  task automatic release_en();
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, error, n, phi, d, gcd_enable, gcd_x, gcd_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {done, error, n, phi, d, gcd_enable, gcd_x, gcd_y});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({done, gcd_enable} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: done/gcd_enable=%b required 00", {done, gcd_enable});
    end
  endtask

  task automatic test_basic();
    res_t obs, expv; bit got; int fg, pg;
    exp_q.push_back(model(5, 11, 3));
    run_key(16'd5, 16'd11, 32'd3, 1'b0, got, obs, fg, pg);
    expv = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0d required 1", got); end
    n_cmp++;
    if (obs !== expv) begin n_fail++; $display("FAIL basic_key: got %s required %s", fmt(obs), fmt(expv)); end
    n_cmp++;
    if ({seen_x, seen_y} !== {32'd3, 32'd40}) begin
      n_fail++; $display("FAIL basic_gcd_xy: got x=%0d y=%0d required x=3 y=40", seen_x, seen_y);
    end
    n_cmp++;
    if (fg !== H + 1) begin n_fail++; $display("FAIL basic_mul_latency: got %0d required %0d", fg, H + 1); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, error, d} !== {1'b1, 1'b0, 32'd27}) begin
      n_fail++; $display("FAIL basic_done_hold: got done=%0d error=%0d d=%0d required 1 0 27", done, error, d);
    end
    release_en();
  endtask

  task automatic test_rsa_classic();
    res_t obs, expv; bit got; int fg, pg, v0;
    v0 = gen_viol;
    exp_q.push_back(model(61, 53, 17));
    run_key(16'd61, 16'd53, 32'd17, 1'b1, got, obs, fg, pg);
    expv = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1 || obs !== expv) begin
      n_fail++; $display("FAIL classic_key: got done=%0d %s required done=1 %s", got, fmt(obs), fmt(expv));
    end
    n_cmp++;
    if (gen_viol - v0 !== 0) begin
      n_fail++; $display("FAIL classic_gcd_handshake: got %0d violations required 0", gen_viol - v0);
    end
    release_en();
  endtask

  task automatic test_gcd_fail();
    res_t obs, expv; bit got; int fg, pg;
    exp_q.push_back(model(5, 11, 4));
    run_key(16'd5, 16'd11, 32'd4, 1'b0, got, obs, fg, pg);
    expv = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1 || obs !== expv) begin
      n_fail++; $display("FAIL gcd_not_one: got done=%0d %s required done=1 %s", got, fmt(obs), fmt(expv));
    end
    release_en();
  endtask

  task automatic test_check_fail();
    logic [H-1:0] tp[4] = '{16'd1, 16'd3, 16'd5, 16'd7};
    logic [H-1:0] tq[4] = '{16'd11, 16'd5, 16'd11, 16'd1};
    logic [W-1:0] te[4] = '{32'd3, 32'd8, 32'd1, 32'd3};
    res_t obs, expv; bit got; int fg, pg;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(model(longint'(tp[k]), longint'(tq[k]), longint'(te[k])));
      run_key(tp[k], tq[k], te[k], 1'b0, got, obs, fg, pg);
      expv = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || obs !== expv) begin
        n_fail++; $display("FAIL check_reject[%0d]: got done=%0d %s required done=1 %s", k, got, fmt(obs), fmt(expv));
      end
      n_cmp++;
      if (fg !== -1) begin
        n_fail++; $display("FAIL check_no_gcd[%0d]: gcd_enable first high at %0d required never", k, fg);
      end
      release_en();
    end
  endtask

  task automatic test_norm();
    res_t obs, expv; bit got; int fg, pg;
    stub_force = 1'b1; force_res = 32'd1;
    force_coeff = -32'sd13;
    exp_q.push_back('{err: 1'b0, n: 32'd55, phi: 32'd40, d: 32'd27});
    run_key(16'd5, 16'd11, 32'd3, 1'b0, got, obs, fg, pg);
    expv = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1 || obs !== expv || pg !== 3) begin
      n_fail++; $display("FAIL norm_negative: got %s cycles=%0d required %s cycles=3", fmt(obs), pg, fmt(expv));
    end
    release_en();
    force_coeff = 32'sd107;
    exp_q.push_back('{err: 1'b0, n: 32'd55, phi: 32'd40, d: 32'd27});
    run_key(16'd5, 16'd11, 32'd3, 1'b0, got, obs, fg, pg);
    expv = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1 || obs !== expv || pg !== 4) begin
      n_fail++; $display("FAIL norm_positive: got %s cycles=%0d required %s cycles=4", fmt(obs), pg, fmt(expv));
    end
    release_en();
    stub_force = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_t obs, expv; bit got; int fg, pg;
    p = 16'd61; q = 16'd53; e = 32'd17; enable = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if ({done, error, n, phi, d, gcd_enable, gcd_x, gcd_y} !== '0) begin
      n_fail++; $display("FAIL reset_mid_mul: got %h required 0", {done, error, n, phi, d, gcd_enable, gcd_x, gcd_y});
    end
    stub_lat = 40;
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (gcd_enable) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_gcd: got %0d required 1", got); end
    repeat (3) @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if ({done, error, n, phi, d, gcd_enable, gcd_x, gcd_y} !== '0) begin
      n_fail++; $display("FAIL reset_mid_gcd: got %h required 0", {done, error, n, phi, d, gcd_enable, gcd_x, gcd_y});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, gcd_enable} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_idle: done/gcd_enable=%b required 00", {done, gcd_enable});
    end
    stub_lat = 3;
    exp_q.push_back(model(5, 11, 3));
    run_key(16'd5, 16'd11, 32'd3, 1'b0, got, obs, fg, pg);
    expv = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1 || obs !== expv) begin
      n_fail++; $display("FAIL reset_mid_rerun: got done=%0d %s required done=1 %s", got, fmt(obs), fmt(expv));
    end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, error, n, phi, d} !== {1'b0, 1'b0, 32'd55, 32'd40, 32'd27}) begin
      n_fail++; $display("FAIL done_release: got done=%0d error=%0d n=%0d phi=%0d d=%0d required 0 0 55 40 27",
                         done, error, n, phi, d);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [H-1:0] tp[5] = '{16'd101, 16'd1009, 16'd257, 16'd40009, 16'd7};
    logic [H-1:0] tq[5] = '{16'd113, 16'd997, 16'd263, 16'd39989, 16'd13};
    logic [W-1:0] te[5] = '{32'd17, 32'd65537, 32'd7, 32'd65537, 32'd5};
    res_t obs, expv; bit got; int fg, pg;
    for (int k = 0; k < 5; k++) begin
      stub_lat = int'($urandom_range(0, 5));
      exp_q.push_back(model(longint'(tp[k]), longint'(tq[k]), longint'(te[k])));
      run_key(tp[k], tq[k], te[k], k[0], got, obs, fg, pg);
      expv = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || obs !== expv) begin
        n_fail++; $display("FAIL b2b[%0d]: got done=%0d %s required done=1 %s", k, got, fmt(obs), fmt(expv));
      end
      enable = 1'b0;
      @(negedge clk);
    end
    stub_lat = 3;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0;
    p = '0; q = '0; e = '0;
    gcd_done = 1'b0; gcd_result = '0; gcd_coeff_i = '0;
    test_reset();
    test_basic();
    test_rsa_classic();
    test_gcd_fail();
    test_check_fail();
    test_norm();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
